// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains a show-ahead FIFO and packs RATIO words per output beat,
// with flush emitting a partial word plus lane mask, and a transfer counter.
module fifo_word_packer #(
  parameter int DWIDTH = 16,
  parameter int RATIO  = 2,
  parameter int CWIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [DWIDTH-1:0]        fifo_q_i,
  input  logic                     fifo_empty_i,
  output logic                     fifo_rdreq_o,
  input  logic                     flush_i,
  output logic [DWIDTH*RATIO-1:0]  data_o,
  output logic [RATIO-1:0]         keep_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [CWIDTH-1:0]        word_cnt_o
);
  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
  typedef enum logic {FILL, FLUSH} state_t;
  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DWIDTH*RATIO-1:0]   asm_q, asm_d, data_q, data_d;
  logic [RATIO-1:0]          akeep_q, akeep_d, keep_q, keep_d;
  logic                      valid_q, valid_d;
  logic [CWIDTH-1:0]         wcnt_q, wcnt_d;
  logic                      out_free, xfer, rd, load_full, load_flush, load;
  assign out_free = !valid_q || ready_i;
  assign xfer     = valid_q && ready_i;
  assign load     = load_full || load_flush;
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) state_q <= FILL;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == FILL ? ((flush_i && cnt_q != '0) ? FLUSH : FILL)
                              : (out_free ? FILL : FLUSH);
  end
  // The final lane is written straight into the output register, so the pop
  // of the last word waits only on output space, never on the assembly register.
  always_comb begin
    rd         = !srst_i && state_q == FILL && !fifo_empty_i &&
                 !(flush_i && cnt_q != '0) && (cnt_q != LAST || out_free);
    load_full  = rd && cnt_q == LAST;
    load_flush = state_q == FLUSH && out_free;
  end
  always_comb begin
    asm_d   = asm_q;
    akeep_d = akeep_q;
    for (int n = 0; n < RATIO - 1; n++) begin
      if (rd && cnt_q == CW'(n)) begin
        asm_d[n*DWIDTH +: DWIDTH] = fifo_q_i;
        akeep_d[n]                = 1'b1;
      end
    end
    if (load) begin
      asm_d   = '0;
      akeep_d = '0;
    end
  end
  always_comb begin
    cnt_d   = load ? '0 : rd ? cnt_q + CW'(1) : cnt_q;
    data_d  = load_full ? {fifo_q_i, asm_q[DWIDTH*(RATIO-1)-1:0]} : load_flush ? asm_q : data_q;
    keep_d  = load_full ? '1 : load_flush ? akeep_q : keep_q;
    valid_d = load || (valid_q && !ready_i);
    wcnt_d  = wcnt_q + CWIDTH'(xfer);
  end
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      akeep_q <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      akeep_q <= akeep_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      wcnt_q  <= wcnt_d;
    end
  end
  assign fifo_rdreq_o = rd;
  assign data_o       = data_q;
  assign keep_o       = keep_q;
  assign valid_o      = valid_q;
  assign word_cnt_o   = wcnt_q;
endmodule
